instruction_rom: RTL and testbench
==================================

Name: instruction_rom

Overview:
- Byte-addressed instruction memory for the single-cycle processor fetch stage.
- Returns the 32-bit instruction at PC combinationally, assembled big-endian from four consecutive bytes.
- Asynchronous active-low reset loads a fixed boot image.
- A synchronous write port reloads program bytes after reset.

Parameters:
- ADDR_W, 10, PC/byte-address width.
- MEM_BYTES, 1024, storage depth in bytes; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; used only by the write port.
- reset  input  1  asynchronous, active-low; loads the boot image.
- PC  input  ADDR_W  byte address of the instruction to fetch.
- wr_en  input  1  write strobe, sampled on posedge clk.
- wr_addr  input  ADDR_W  byte address of the word to write.
- wr_data  input  32  word to write, big-endian.
- Instruction_Code  output  32  fetched instruction.

Behaviour:
- Storage: MEM_BYTES x 8-bit array.
- Reset:
  - One clock; reset is asynchronous and active-low.
  - On reset low: immediately, without a clock edge, byte array = boot image.
    - Words 0..7 (bytes 0..31) come from package constant BOOT_IMAGE.
    - All other bytes are 0x00.
  - Image held while reset stays low.
  - Contents before the first reset are undefined.
- Read (combinational, zero latency):
  - Instruction_Code = {mem[PC], mem[PC+1], mem[PC+2], mem[PC+3]}.
  - Byte at PC is the MSB.
  - Valid during reset, reflecting the image.
- Address arithmetic:
  - PC+k is computed modulo MEM_BYTES, ADDR_W bits.
  - PC=1022 reads bytes 1022, 1023, 0, 1.
- Unaligned PC is permitted (byte granularity) unless the optional feature is enabled.
- Write:
  - On posedge clk with reset high and wr_en=1: mem[wr_addr+k] = wr_data[31-8k -: 8] for k=0..3, same modulo wrap.
  - Read reflects the new data combinationally after the edge.
- Writes are ignored while reset is low.
- Reset asserting in the same cycle as a write: reset wins and the image is restored.
- PC==wr_addr in a write cycle: output shows old data until the edge, new data after it.
- BOOT_IMAGE (word index: value):
  - 0: 00A00093
  - 1: 01400113
  - 2: 002081B3
  - 3: 40208233
  - 4: 0020F2B3
  - 5: 0020E333
  - 6: 00000013
  - 7: 0000006F
- PC undriven (X) gives an X output; no special handling.

Optional Feature:
- Macro: IMEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned (1 bit), equal to |PC[1:0].
  - When misaligned=1, Instruction_Code = 32'h00000013 (NOP).
  - Writes with wr_addr[1:0]!=0 are ignored.
- Undefined:
  - No misaligned port.
  - Byte-granular unaligned reads and writes as above.

Decomposition:
- Package imem_pkg holds:
  - INSTR_W=32;
  - BYTE_W=8;
  - NOP_INSTR=32'h00000013;
  - BOOT_WORDS=8;
  - BOOT_IMAGE array of 8 x 32-bit words;
  - a function returning the boot byte for a given address.
- One natural sub-module: imem_word_read, a 4-byte big-endian gather with modulo address increment.
- The write path and reset load stay in the top module.

Test Plan:
- Reset low at t=0, PC=0 -> Instruction_Code=00A00093 while reset is still low; release reset, PC=4 -> 01400113.
- PC sweep 0,4,...,28 after reset -> the eight BOOT_IMAGE words in order; PC=32..52 -> 00000000.
- Unaligned/wrap (feature off):
  - PC=2 -> 00930140.
  - PC=1022 -> {mem[1022], mem[1023], mem[0], mem[1]} = 000000A0.
- Write:
  - wr_en=1, wr_addr=40, wr_data=DEADBEEF at posedge -> PC=40 reads DEADBEEF after the edge, 00000000 before it.
  - With reset low during the same edge -> the write is ignored.
- Reset mid-operation: write 12345678 at addr 0, then pulse reset low asynchronously between edges -> PC=0 immediately reads 00A00093.
- IMEM_ALIGN_CHECK_EN defined:
  - PC=6 -> misaligned=1, Instruction_Code=00000013.
  - PC=8 -> misaligned=0, 002081B3.
  - Write at wr_addr=5 -> no change.

Source files
------------

// File: rtl/instruction_rom_pkg.sv
// Shared constants and boot image for the byte-addressed instruction memory.
// Optional macro IMEM_ALIGN_CHECK_EN is handled in the interface and top, not here.
package imem_pkg;

    localparam int INSTR_W    = 32;
    localparam int BYTE_W     = 8;
    localparam int BOOT_WORDS = 8;
    localparam int unsigned BOOT_BYTES = 32'd32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [INSTR_W-1:0] BOOT_IMAGE [BOOT_WORDS] = '{
        32'h00A0_0093,
        32'h0140_0113,
        32'h0020_81B3,
        32'h4020_8233,
        32'h0020_F2B3,
        32'h0020_E333,
        32'h0000_0013,
        32'h0000_006F
    };

    // Boot byte at a byte address; the image is stored big-endian, zero beyond it.
    function automatic logic [BYTE_W-1:0] boot_byte(input int unsigned addr);
        logic [INSTR_W-1:0] word;
        logic [2:0]         widx;
        logic [BYTE_W-1:0]  result;
        widx = addr[4:2];
        word = BOOT_IMAGE[widx];
        if (addr < BOOT_BYTES) begin
            case (addr[1:0])
                2'd0:    result = word[31:24];
                2'd1:    result = word[23:16];
                2'd2:    result = word[15:8];
                2'd3:    result = word[7:0];
                default: result = 8'h00;
            endcase
        end else begin
            result = 8'h00;
        end
        return result;
    endfunction

endpackage

// File: rtl/instruction_rom_if.sv
// Fetch and write-port bundle for instruction_rom.
// IMEM_ALIGN_CHECK_EN adds the misaligned flag.
interface instruction_rom_if #(
    parameter int ADDR_W = 10
);
    import imem_pkg::*;

    logic [ADDR_W-1:0]  PC;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic [INSTR_W-1:0] Instruction_Code;
`ifdef IMEM_ALIGN_CHECK_EN
    logic               misaligned;

    modport master (output PC, wr_en, wr_addr, wr_data, input Instruction_Code, misaligned);
    modport slave  (input PC, wr_en, wr_addr, wr_data, output Instruction_Code, misaligned);
`else
    modport master (output PC, wr_en, wr_addr, wr_data, input Instruction_Code);
    modport slave  (input PC, wr_en, wr_addr, wr_data, output Instruction_Code);
`endif

endinterface

// File: rtl/instruction_rom_word_read.sv
// Gathers four consecutive bytes big-endian; the byte address wraps at the array size.
module imem_word_read
    import imem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic [BYTE_W-1:0]  mem [MEM_BYTES],
    input  logic [ADDR_W-1:0]  addr,
    output logic [INSTR_W-1:0] word
);

    logic [ADDR_W-1:0] addr1_s;
    logic [ADDR_W-1:0] addr2_s;
    logic [ADDR_W-1:0] addr3_s;

    // ADDR_W-bit sums wrap modulo the array depth.
    always_comb begin
        addr1_s = addr + ADDR_W'(1);
        addr2_s = addr + ADDR_W'(2);
        addr3_s = addr + ADDR_W'(3);
        word    = {mem[addr], mem[addr1_s], mem[addr2_s], mem[addr3_s]};
    end

endmodule

// File: rtl/instruction_rom.sv
// Byte-addressed instruction memory: async active-low reset loads the boot image,
// combinational big-endian fetch, synchronous word write. Macro: IMEM_ALIGN_CHECK_EN.
module instruction_rom
    import imem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_rom_if.slave      bus
);

    logic [BYTE_W-1:0]  mem_r [MEM_BYTES];
    logic [INSTR_W-1:0] word_s;
    logic               wr_ok_s;

    // Write qualification: aligned-only when the alignment check is built in.
    always_comb begin
`ifdef IMEM_ALIGN_CHECK_EN
        wr_ok_s = bus.wr_en & (bus.wr_addr[1:0] == 2'b00);
`else
        wr_ok_s = bus.wr_en;
`endif
    end

    // Byte array: reset reloads the boot image and holds it while low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_r[i] <= boot_byte(i);
            end
        end else if (wr_ok_s) begin
            for (int k = 0; k < 4; k++) begin
                mem_r[bus.wr_addr + ADDR_W'(k)] <= bus.wr_data[31-8*k -: 8];
            end
        end else begin
            mem_r <= mem_r;
        end
    end

    imem_word_read #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_word_read (
        .mem  (mem_r),
        .addr (bus.PC),
        .word (word_s)
    );

    // Fetch output; misaligned fetches substitute a NOP when checking is enabled.
    always_comb begin
`ifdef IMEM_ALIGN_CHECK_EN
        bus.misaligned = |bus.PC[1:0];
        if (bus.misaligned) begin
            bus.Instruction_Code = NOP_INSTR;
        end else begin
            bus.Instruction_Code = word_s;
        end
`else
        bus.Instruction_Code = word_s;
`endif
    end

endmodule

// File: tb/tb_instruction_rom.sv
// Randomized self-checking bench for instruction_rom against a byte-array reference model.
module tb_instruction_rom;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    byte unsigned ref_mem [DEPTH];
    logic [31:0]  boot_tab [8];

    instruction_rom_if #(.ADDR_W(AW)) bus ();

    instruction_rom #(.ADDR_W(AW), .MEM_BYTES(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit align_on();
`ifdef IMEM_ALIGN_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        for (int w = 0; w < 8; w++) begin
            ref_mem[4*w]   = boot_tab[w][31:24];
            ref_mem[4*w+1] = boot_tab[w][23:16];
            ref_mem[4*w+2] = boot_tab[w][15:8];
            ref_mem[4*w+3] = boot_tab[w][7:0];
        end
    endtask

    function automatic logic [31:0] model_read(input int pc);
        if (align_on() && (pc % 4) != 0) return 32'h0000_0013;
        return {ref_mem[pc % DEPTH], ref_mem[(pc + 1) % DEPTH],
                ref_mem[(pc + 2) % DEPTH], ref_mem[(pc + 3) % DEPTH]};
    endfunction

    task automatic read_check(input string tag, input int pc);
        bus.PC = AW'(pc);
        #1;
        check_val(tag, bus.Instruction_Code, model_read(pc));
`ifdef IMEM_ALIGN_CHECK_EN
        check_val({tag, "_mis"}, {31'd0, bus.misaligned}, {31'd0, (pc % 4) != 0});
`endif
    endtask

    task automatic do_write(input int addr, input logic [31:0] data, input bit en);
        @(negedge clk);
        bus.wr_en   = en;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        if (en && reset && !(align_on() && (addr % 4) != 0)) begin
            for (int k = 0; k < 4; k++) ref_mem[(addr + k) % DEPTH] = data[31-8*k -: 8];
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        boot_tab = '{32'h00A00093, 32'h01400113, 32'h002081B3, 32'h40208233,
                     32'h0020F2B3, 32'h0020E333, 32'h00000013, 32'h0000006F};
        reset       = 1'b1;
        bus.PC      = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        #1 reset = 1'b0;
        model_reset();
        #1;
        check_val("rst_pc0", bus.Instruction_Code, 32'h00A00093);

        // A write during reset is dropped.
        do_write(40, 32'hDEADBEEF, 1'b1);
        bus.PC = AW'(40);
        #1;
        check_val("wr_in_reset", bus.Instruction_Code, 32'h00000000);

        @(negedge clk);
        reset = 1'b1;
        bus.PC = AW'(4);
        #1;
        check_val("rel_pc4", bus.Instruction_Code, 32'h01400113);

        for (int p = 0; p <= 52; p += 4) begin
            read_check("sweep", p);
            if (p < 32) check_val("boot_word", bus.Instruction_Code, boot_tab[p/4]);
        end

`ifndef IMEM_ALIGN_CHECK_EN
        bus.PC = AW'(2);
        #1;
        check_val("unaligned_pc2", bus.Instruction_Code, 32'h00930140);
        bus.PC = AW'(1022);
        #1;
        check_val("wrap_pc1022", bus.Instruction_Code, 32'h000000A0);
`else
        bus.PC = AW'(6);
        #1;
        check_val("mis_pc6", bus.Instruction_Code, 32'h00000013);
        check_val("mis_flag6", {31'd0, bus.misaligned}, 32'd1);
        bus.PC = AW'(8);
        #1;
        check_val("al_pc8", bus.Instruction_Code, 32'h002081B3);
        check_val("al_flag8", {31'd0, bus.misaligned}, 32'd0);
        do_write(5, 32'hCAFEF00D, 1'b1);
        bus.PC = AW'(4);
        #1;
        check_val("mis_wr_pc4", bus.Instruction_Code, 32'h01400113);
        bus.PC = AW'(8);
        #1;
        check_val("mis_wr_pc8", bus.Instruction_Code, 32'h002081B3);
`endif

        // Write at 40: old data before the edge, new data after.
        @(negedge clk);
        bus.PC      = AW'(40);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(40);
        bus.wr_data = 32'hDEADBEEF;
        #1;
        check_val("wr_before", bus.Instruction_Code, 32'h00000000);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        for (int k = 0; k < 4; k++) ref_mem[40 + k] = 8'(32'hDEADBEEF >> (24 - 8*k));
        check_val("wr_after", bus.Instruction_Code, 32'hDEADBEEF);

        // Overwrite word 0 then reset asynchronously between edges.
        do_write(0, 32'h12345678, 1'b1);
        read_check("wr_addr0", 0);
        check_val("wr_addr0_const", bus.Instruction_Code, 32'h12345678);
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        #1;
        check_val("async_rst", bus.Instruction_Code, 32'h00A00093);
        read_check("async_rst_pc40", 40);
        @(negedge clk);
        reset = 1'b1;

        for (int it = 0; it < 150; it++) begin
            int a;
            a = (it % 3 == 0) ? (($urandom_range(0, 255)) * 4) : $urandom_range(0, DEPTH - 1);
            if (it % 10 == 0) a = DEPTH - 1 - $urandom_range(0, 2);
            do_write(a, $urandom, 1'($urandom_range(0, 1)));
            read_check("rnd_wa", a);
            read_check("rnd_wa_al", a & ~3);
            read_check("rnd_any", $urandom_range(0, DEPTH - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
